// File: rtl/lcd_hd44780_pkg.sv
// Shared HD44780 definitions: opcodes, DDRAM line bases, responder FSM states and
// address helpers. Used by the LCD responder and by the controllers that drive it.
package lcd_hd44780_pkg;

  localparam logic [7:0] CLEAR_DISPLAY = 8'h01;
  localparam logic [7:0] RETURN_HOME   = 8'h02;
  localparam logic [7:0] ENTRY_MODE    = 8'h04;
  localparam logic [7:0] DISP_CTRL     = 8'h08;
  localparam logic [7:0] SHIFT         = 8'h10;
  localparam logic [7:0] FUNC_SET      = 8'h20;
  localparam logic [7:0] SET_CGRAM     = 8'h40;
  localparam logic [7:0] SET_DDRAM     = 8'h80;

  localparam logic [7:0] DDRAM_LINE0_BASE = 8'h80;
  localparam logic [7:0] DDRAM_LINE1_BASE = 8'hC0;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_EXEC       = 2'd1;
  localparam logic [1:0] ST_CLEAR_FILL = 2'd2;

  localparam int DDRAM_BYTES = 80;
  localparam int LINE_CHARS  = 40;

  // Line 2 (AC[6]=1) starts 40 bytes into the flat DDRAM array.
  function automatic logic [6:0] ddram_index(input logic [6:0] a);
    return a[6] ? (7'd40 + {1'b0, a[5:0]}) : {1'b0, a[5:0]};
  endfunction

  function automatic logic [5:0] shift_step(input logic [5:0] ofs, input logic inc);
    if (inc) return (ofs >= 6'd39) ? 6'd0 : ofs + 6'd1;
    return (ofs == 6'd0) ? 6'd39 : ofs - 6'd1;
  endfunction

endpackage

// File: rtl/lcd_ac_step.sv
// Combinational next address-counter value: one step up or down, honouring the
// CGRAM 6-bit wrap and the one-line / two-line DDRAM wrap points.
module lcd_ac_step (
  input  logic [6:0] ac,
  input  logic       inc,
  input  logic       cg_mode,
  input  logic       two_line,
  output logic [6:0] ac_next
);

  always_comb begin
    ac_next = inc ? ac + 7'd1 : ac - 7'd1;
    if (cg_mode) begin
      ac_next = {1'b0, (inc ? ac[5:0] + 6'd1 : ac[5:0] - 6'd1)};
    end else if (two_line) begin
      if (inc && ac == 7'h27)       ac_next = 7'h40;
      else if (inc && ac == 7'h67)  ac_next = 7'h00;
      else if (!inc && ac == 7'h40) ac_next = 7'h27;
      else if (!inc && ac == 7'h00) ac_next = 7'h67;
    end else begin
      if (inc && ac == 7'h4F)       ac_next = 7'h00;
      else if (!inc && ac == 7'h00) ac_next = 7'h4F;
    end
  end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// HD44780 LCD-side bus responder: instruction decode, DDRAM/CGRAM, AC and busy timing.
// Optional bus read-back (busy flag / AC and memory reads) is enabled by LCD_RESP_READ_EN.
module lcd_hd44780_responder
  import lcd_hd44780_pkg::*;
#(
  parameter int BUSY_CYCLES  = 4,
  parameter int HOME_CYCLES  = 16,
  parameter int CLEAR_CYCLES = 82
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] data_o,
  output logic       busy,
  output logic [6:0] ac,
  output logic       cg_mode,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       two_line,
  output logic       mode_8bit,
  output logic       font_5x10,
  output logic       entry_inc,
  output logic       entry_shift,
  output logic [5:0] shift_ofs,
  output logic       cmd_err,
  input  logic       dbg_sel,
  input  logic [6:0] dbg_addr,
  output logic [7:0] dbg_data
);

  logic [7:0] ddram [0:DDRAM_BYTES-1];
  logic [7:0] cgram [0:63];

  logic [1:0] state_reg;
  logic [7:0] cnt_reg;
  logic [6:0] fill_reg;
  logic       en_q_reg;
  logic [6:0] ac_reg;
  logic       cg_mode_reg, disp_on_reg, cursor_on_reg, blink_on_reg;
  logic       two_line_reg, mode_8bit_reg, font_5x10_reg;
  logic       entry_inc_reg, entry_shift_reg;
  logic [5:0] shift_reg;
  logic       cmd_err_reg;
  logic [7:0] dbg_data_reg;

  logic       strobe, cmd_strobe, accept, data_rd, data_wr, inc_sel;
  logic [6:0] ac_next, dd_idx, dbg_idx;
  logic       dd_ok, dbg_ok;

  assign strobe  = en_q_reg & ~enable;
  assign busy    = (state_reg != ST_IDLE);
  assign dd_idx  = ddram_index(ac_reg);
  assign dd_ok   = (dd_idx < 7'(DDRAM_BYTES));
  assign dbg_idx = ddram_index(dbg_addr);
  assign dbg_ok  = (dbg_idx < 7'(DDRAM_BYTES));

`ifdef LCD_RESP_READ_EN
  logic [7:0] data_o_reg;
  logic [7:0] mem_rd;
  assign data_rd    = rs & rw;
  // Status reads (rs=0, rw=1) are never commands, so they are legal while busy.
  assign cmd_strobe = strobe & (~rw | rs);
  assign mem_rd     = cg_mode_reg ? cgram[ac_reg[5:0]] : (dd_ok ? ddram[dd_idx] : 8'h00);
  assign data_o     = data_o_reg;
`else
  assign data_rd    = 1'b0;
  assign cmd_strobe = strobe & ~rw;
  assign data_o     = 8'h00;
`endif

  assign accept  = cmd_strobe & ~busy;
  assign data_wr = accept & rs & ~rw;
  // Cursor-shift instructions pick direction from R/L; data accesses from I/D.
  assign inc_sel = rs ? entry_inc_reg : data[2];

  lcd_ac_step u_ac_step (
    .ac       (ac_reg),
    .inc      (inc_sel),
    .cg_mode  (cg_mode_reg),
    .two_line (two_line_reg),
    .ac_next  (ac_next)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state_reg == ST_CLEAR_FILL && fill_reg < 7'(DDRAM_BYTES))
        ddram[fill_reg] <= 8'h20;
      else if (data_wr && !cg_mode_reg && dd_ok)
        ddram[dd_idx] <= data;
      if (data_wr && cg_mode_reg)
        cgram[ac_reg[5:0]] <= data;
    end
    dbg_data_reg <= dbg_sel ? cgram[dbg_addr[5:0]] : (dbg_ok ? ddram[dbg_idx] : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= 8'd0;
      fill_reg        <= 7'd0;
      en_q_reg        <= 1'b0;
      ac_reg          <= 7'd0;
      cg_mode_reg     <= 1'b0;
      disp_on_reg     <= 1'b0;
      cursor_on_reg   <= 1'b0;
      blink_on_reg    <= 1'b0;
      two_line_reg    <= 1'b0;
      mode_8bit_reg   <= 1'b1;
      font_5x10_reg   <= 1'b0;
      entry_inc_reg   <= 1'b1;
      entry_shift_reg <= 1'b0;
      shift_reg       <= 6'd0;
      cmd_err_reg     <= 1'b0;
`ifdef LCD_RESP_READ_EN
      data_o_reg      <= 8'h00;
`endif
    end else begin
      en_q_reg    <= enable;
      cmd_err_reg <= cmd_strobe & busy;
`ifdef LCD_RESP_READ_EN
      if (enable && !rs && rw) data_o_reg <= {busy, ac_reg};
      else if (accept && data_rd) data_o_reg <= mem_rd;
      else data_o_reg <= 8'h00;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            state_reg <= ST_EXEC;
            cnt_reg   <= 8'(BUSY_CYCLES - 1);
            if (rs) begin
              ac_reg <= ac_next;
              if (entry_shift_reg && !cg_mode_reg)
                shift_reg <= shift_step(shift_reg, entry_inc_reg);
            end else if (data[7]) begin
              if (data[5:0] < 6'(LINE_CHARS)) begin
                ac_reg      <= data[6:0];
                cg_mode_reg <= 1'b0;
              end else begin
                cmd_err_reg <= 1'b1;
              end
            end else if (data[6]) begin
              ac_reg      <= {1'b0, data[5:0]};
              cg_mode_reg <= 1'b1;
            end else if (data[5]) begin
              mode_8bit_reg <= data[4];
              two_line_reg  <= data[3];
              font_5x10_reg <= data[2];
            end else if (data[4]) begin
              if (data[3]) shift_reg <= shift_step(shift_reg, data[2]);
              else         ac_reg    <= ac_next;
            end else if (data[3]) begin
              disp_on_reg   <= data[2];
              cursor_on_reg <= data[1];
              blink_on_reg  <= data[0];
            end else if (data[2]) begin
              entry_inc_reg   <= data[1];
              entry_shift_reg <= data[0];
            end else if (data[1]) begin
              cnt_reg     <= 8'(HOME_CYCLES - 1);
              ac_reg      <= 7'd0;
              shift_reg   <= 6'd0;
              cg_mode_reg <= 1'b0;
            end else if (data[0]) begin
              state_reg     <= ST_CLEAR_FILL;
              cnt_reg       <= 8'(CLEAR_CYCLES - 1);
              fill_reg      <= 7'd0;
              ac_reg        <= 7'd0;
              shift_reg     <= 6'd0;
              entry_inc_reg <= 1'b1;
              cg_mode_reg   <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          if (cnt_reg == 8'd0) state_reg <= ST_IDLE;
          else                 cnt_reg   <= cnt_reg - 8'd1;
        end
        ST_CLEAR_FILL: begin
          if (fill_reg < 7'(DDRAM_BYTES)) fill_reg <= fill_reg + 7'd1;
          if (cnt_reg == 8'd0) state_reg <= ST_IDLE;
          else                 cnt_reg   <= cnt_reg - 8'd1;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign ac          = ac_reg;
  assign cg_mode     = cg_mode_reg;
  assign disp_on     = disp_on_reg;
  assign cursor_on   = cursor_on_reg;
  assign blink_on    = blink_on_reg;
  assign two_line    = two_line_reg;
  assign mode_8bit   = mode_8bit_reg;
  assign font_5x10   = font_5x10_reg;
  assign entry_inc   = entry_inc_reg;
  assign entry_shift = entry_shift_reg;
  assign shift_ofs   = shift_reg;
  assign cmd_err     = cmd_err_reg;
  assign dbg_data    = dbg_data_reg;

endmodule
